// File: rtl/ball_frame_sender.sv
// rtl/ball_frame_sender.sv - Captures ball state and sends it as an I2C byte frame with bounded retries
// Optional BALL_FRAME_CHECKSUM_EN appends an XOR checksum byte and moves m_last onto it.
module ball_frame_sender #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h17,
  parameter int         DONE_HOLD   = 4,
  parameter int         ACK_TIMEOUT = 250000,
  parameter int         MAX_RETRY   = 2
) (
  input  logic       clk_25MHZ,
  input  logic       reset_n,
  input  logic       ball_send_trigger,
  input  logic [9:0] ball_y_in,
  input  logic [7:0] ball_vy_in,
  input  logic [1:0] gravity_counter_in,
  input  logic       ball_fast_in,
  input  logic       is_lose_in,
  output logic       m_start,
  output logic [6:0] m_addr,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  input  logic       m_nack,
  input  logic       m_stop_done,
  output logic       ball_send_to_slave,
  output logic       is_i2c_master_done,
  output logic       frame_err
);

`ifdef BALL_FRAME_CHECKSUM_EN
  localparam int NBYTES = 7;
`else
  localparam int NBYTES = 6;
`endif
  localparam int              TW        = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0]   TO_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam int              RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [2:0]      IDX_LAST  = 3'(NBYTES - 1);
  localparam logic [7:0]      HOLD_LAST = 8'(DONE_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_STOP,
    S_FAIL,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_trig_prev;
  logic          r_start;
  logic          r_frame_err;
  logic [9:0]    r_y;
  logic [7:0]    r_vy;
  logic [1:0]    r_grav;
  logic          r_fast;
  logic          r_lose;
  logic [2:0]    r_idx;
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_hold;

  logic          w_valid;
  logic          w_timeout;
  logic          w_trig_rise;
  logic [7:0]    w_byte;

  assign w_valid     = (r_state == S_SEND);
  assign w_timeout   = (r_timer == TO_LAST);
  assign w_trig_rise = ball_send_trigger && !r_trig_prev;

`ifdef BALL_FRAME_CHECKSUM_EN
  logic [7:0] w_csum;
  assign w_csum = {r_y[9:8], 6'b0} ^ r_y[7:0] ^ r_vy ^ {6'b0, r_grav} ^
                  {7'b0, r_fast} ^ {7'b0, r_lose};
`endif

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      3'd0: w_byte = {r_y[9:8], 6'b0};
      3'd1: w_byte = r_y[7:0];
      3'd2: w_byte = r_vy;
      3'd3: w_byte = {6'b0, r_grav};
      3'd4: w_byte = {7'b0, r_fast};
      3'd5: w_byte = {7'b0, r_lose};
`ifdef BALL_FRAME_CHECKSUM_EN
      3'd6: w_byte = w_csum;
`endif
      default: w_byte = 8'h00;
    endcase
  end

  assign m_addr             = SLAVE_ADDR;
  assign m_start            = r_start;
  assign m_valid            = w_valid;
  assign m_data             = w_valid ? w_byte : 8'h00;
  assign m_last             = w_valid && (r_idx == IDX_LAST);
  assign ball_send_to_slave = (r_state != S_IDLE);
  assign is_i2c_master_done = (r_state == S_DONE);
  assign frame_err          = r_frame_err;

  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_trig_prev <= 1'b0;
      r_start     <= 1'b0;
      r_frame_err <= 1'b0;
      r_y         <= '0;
      r_vy        <= '0;
      r_grav      <= '0;
      r_fast      <= 1'b0;
      r_lose      <= 1'b0;
      r_idx       <= '0;
      r_retry     <= '0;
      r_timer     <= '0;
      r_hold      <= '0;
    end else begin
      r_trig_prev <= ball_send_trigger;
      r_start     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trig_rise) begin
            r_y     <= ball_y_in;
            r_vy    <= ball_vy_in;
            r_grav  <= gravity_counter_in;
            r_fast  <= ball_fast_in;
            r_lose  <= is_lose_in;
            r_idx   <= '0;
            r_retry <= '0;
            r_timer <= '0;
            r_start <= 1'b1;
            r_state <= S_SEND;
          end
        end
        // NACK beats a same-cycle ACK; an ACK on the last allowed cycle still counts.
        S_SEND: begin
          if (m_nack) begin
            r_timer <= '0;
            r_state <= S_FAIL;
          end else if (m_ready) begin
            r_timer <= '0;
            if (r_idx == IDX_LAST) begin
              r_state <= S_WAIT_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else if (w_timeout) begin
            r_timer <= '0;
            r_state <= S_FAIL;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_WAIT_STOP: begin
          if (m_stop_done) begin
            r_frame_err <= 1'b0;
            r_hold      <= '0;
            r_state     <= S_DONE;
          end else if (w_timeout) begin
            r_timer <= '0;
            r_state <= S_FAIL;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_FAIL: begin
          if (r_retry < RETRY_MAX) begin
            r_retry <= r_retry + RW'(1);
            r_idx   <= '0;
            r_timer <= '0;
            r_start <= 1'b1;
            r_state <= S_SEND;
          end else begin
            r_frame_err <= 1'b1;
            r_hold      <= '0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_hold == HOLD_LAST) begin
            r_frame_err <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_frame_sender.sv
// tb/tb_ball_frame_sender.sv - Directed self-checking bench for ball_frame_sender
module tb_ball_frame_sender;

`ifdef BALL_FRAME_CHECKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic       clk_25MHZ = 1'b0;
  logic       reset_n = 1'b0;
  logic       ball_send_trigger = 1'b0;
  logic [9:0] ball_y_in = '0;
  logic [7:0] ball_vy_in = '0;
  logic [1:0] gravity_counter_in = '0;
  logic       ball_fast_in = 1'b0;
  logic       is_lose_in = 1'b0;
  logic       m_ready = 1'b0;
  logic       m_nack = 1'b0;
  logic       m_stop_done = 1'b0;
  logic       m_start;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       ball_send_to_slave;
  logic       is_i2c_master_done;
  logic       frame_err;

  int n_checks = 0;
  int n_pass = 0;
  int start_cnt = 0;
  logic [7:0] exp_b [0:6];

  ball_frame_sender #(
    .SLAVE_ADDR(7'h17), .DONE_HOLD(4), .ACK_TIMEOUT(16), .MAX_RETRY(2)
  ) dut (
    .clk_25MHZ(clk_25MHZ), .reset_n(reset_n), .ball_send_trigger(ball_send_trigger),
    .ball_y_in(ball_y_in), .ball_vy_in(ball_vy_in), .gravity_counter_in(gravity_counter_in),
    .ball_fast_in(ball_fast_in), .is_lose_in(is_lose_in), .m_start(m_start), .m_addr(m_addr),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .m_nack(m_nack),
    .m_stop_done(m_stop_done), .ball_send_to_slave(ball_send_to_slave),
    .is_i2c_master_done(is_i2c_master_done), .frame_err(frame_err)
  );

  always #20 clk_25MHZ = ~clk_25MHZ;

  always @(negedge clk_25MHZ) if (m_start) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk_25MHZ);
  endtask

  task automatic load_inputs(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] g,
                             input logic f, input logic l);
    ball_y_in = y; ball_vy_in = vy; gravity_counter_in = g; ball_fast_in = f; is_lose_in = l;
    exp_b[0] = {y[9:8], 6'b0};
    exp_b[1] = y[7:0];
    exp_b[2] = vy;
    exp_b[3] = {6'b0, g};
    exp_b[4] = {7'b0, f};
    exp_b[5] = {7'b0, l};
    exp_b[6] = exp_b[0] ^ exp_b[1] ^ exp_b[2] ^ exp_b[3] ^ exp_b[4] ^ exp_b[5];
  endtask

  task automatic trigger_pulse(input string tag);
    ball_send_trigger = 1'b1;
    tick();
    ball_send_trigger = 1'b0;
    check({tag, " start"}, m_start, 1);
    check({tag, " busy"}, ball_send_to_slave, 1);
  endtask

  task automatic send_bytes(input int nack_at, input logic with_ready, input string tag);
    for (int i = 0; i < NB; i++) begin
      check({tag, " valid"}, m_valid, 1);
      check({tag, " data"}, m_data, exp_b[i]);
      check({tag, " last"}, m_last, (i == NB - 1));
      if (i == nack_at) begin
        m_nack = 1'b1; m_ready = with_ready;
        tick();
        m_nack = 1'b0; m_ready = 1'b0;
        check({tag, " fail_valid"}, m_valid, 0);
        check({tag, " fail_busy"}, ball_send_to_slave, 1);
        return;
      end
      m_ready = 1'b1;
      tick();
    end
    m_ready = 1'b0;
    check({tag, " wait_stop_valid"}, m_valid, 0);
    check({tag, " wait_stop_done"}, is_i2c_master_done, 0);
  endtask

  task automatic finish_done(input logic exp_err, input string tag);
    int n = 0;
    check({tag, " done"}, is_i2c_master_done, 1);
    check({tag, " frame_err"}, frame_err, exp_err);
    while (is_i2c_master_done && n < 20) begin
      n++;
      tick();
    end
    check({tag, " done_cycles"}, n, 4);
    check({tag, " busy_after"}, ball_send_to_slave, 0);
    check({tag, " err_after"}, frame_err, 0);
  endtask

  task automatic stop_ok(input string tag);
    m_stop_done = 1'b1;
    tick();
    m_stop_done = 1'b0;
    finish_done(1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(); tick();
    check("rst m_start", m_start, 0);
    check("rst m_valid", m_valid, 0);
    check("rst m_data", m_data, 0);
    check("rst m_last", m_last, 0);
    check("rst busy", ball_send_to_slave, 0);
    check("rst done", is_i2c_master_done, 0);
    check("rst frame_err", frame_err, 0);
    check("rst m_addr", m_addr, 7'h17);
    reset_n = 1'b1;
    tick();

    // Nominal frame against hand-computed bytes
    load_inputs(10'h2A5, 8'hFD, 2'd2, 1'b1, 1'b0);
    exp_b[0] = 8'h80; exp_b[1] = 8'hA5; exp_b[2] = 8'hFD; exp_b[3] = 8'h02;
    exp_b[4] = 8'h01; exp_b[5] = 8'h00; exp_b[6] = 8'hDB;
    start_cnt = 0;
    trigger_pulse("nominal");
    send_bytes(-1, 1'b0, "nominal");
    tick();
    check("nominal still_waiting", ball_send_to_slave, 1);
    stop_ok("nominal");
    check("nominal starts", start_cnt, 1);

    // Held trigger, stop_done ignored in SEND, then fresh edge with shadowed inputs
    load_inputs(10'h155, 8'h10, 2'd1, 1'b0, 1'b1);
    start_cnt = 0;
    ball_send_trigger = 1'b1;
    tick();
    check("held start", m_start, 1);
    m_stop_done = 1'b1;
    tick();
    m_stop_done = 1'b0;
    send_bytes(-1, 1'b0, "held");
    stop_ok("held");
    repeat (1000) tick();
    check("held starts", start_cnt, 1);
    check("held idle", ball_send_to_slave, 0);
    ball_send_trigger = 1'b0;
    tick();
    load_inputs(10'h3C3, 8'h80, 2'd3, 1'b1, 1'b1);
    trigger_pulse("shadow");
    ball_y_in = 10'h000; ball_vy_in = 8'h55; is_lose_in = 1'b0;
    send_bytes(-1, 1'b0, "shadow");
    stop_ok("shadow");
    check("shadow starts", start_cnt, 2);

    // NACK together with ACK on B2, then clean retry
    load_inputs(10'h0F0, 8'h7F, 2'd0, 1'b0, 1'b0);
    start_cnt = 0;
    trigger_pulse("nack");
    send_bytes(2, 1'b1, "nack");
    tick();
    check("nack restart", m_start, 1);
    send_bytes(-1, 1'b0, "retry");
    stop_ok("retry");
    check("retry starts", start_cnt, 2);

    // Every attempt NACKed
    load_inputs(10'h201, 8'hC0, 2'd1, 1'b1, 1'b0);
    start_cnt = 0;
    trigger_pulse("exh");
    for (int a = 0; a < 3; a++) begin
      send_bytes(1, 1'b0, "exh");
      tick();
      if (a < 2) check("exh restart", m_start, 1);
    end
    finish_done(1'b1, "exh");
    check("exh starts", start_cnt, 3);

    // Timeout with m_ready stuck low, then asynchronous reset mid-SEND
    load_inputs(10'h011, 8'h01, 2'd2, 1'b0, 1'b1);
    trigger_pulse("timeout");
    n = 0;
    while (m_valid && n < 40) begin
      n++;
      tick();
    end
    check("timeout send_cycles", n, 16);
    check("timeout fail_busy", ball_send_to_slave, 1);
    tick();
    check("timeout restart", m_start, 1);
    check("timeout resend_b0", m_data, exp_b[0]);
    tick(); tick();
    #5 reset_n = 1'b0;
    #1;
    check("async_rst valid", m_valid, 0);
    check("async_rst busy", ball_send_to_slave, 0);
    check("async_rst data", m_data, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst idle", ball_send_to_slave, 0);
    check("post_rst start", m_start, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ball_frame_sender.md
# ball_frame_sender

Downstream of the game controller. The block captures the outgoing ball state when `ball_send_trigger` asserts and serialises it as a fixed byte frame into the I2C master byte interface. The frame layout matches the opponent board's slave registers reg0–reg5. It returns the `ball_send_to_slave` busy acknowledge and the `is_i2c_master_done` completion level that the controller's SEND_BALL and SEND_LOSE states wait on. NACK and timeout errors are handled with bounded retries, so the controller never hangs.

## Interface
- `SLAVE_ADDR`, default 7'h17: opponent board I2C address, driven on `m_addr`.
- `DONE_HOLD`, default 4: number of cycles `is_i2c_master_done` stays high (valid range 1–255).
- `ACK_TIMEOUT`, default 250000: maximum idle cycles waiting on `m_ready` or `m_stop_done` (10 ms at 25 MHz).
- `MAX_RETRY`, default 2: re-sends of a frame after a failed attempt.
- `clk_25MHZ` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ball_send_trigger` in 1: level request from the controller; captured on a rising edge only.
- `ball_y_in` in 10: ball Y position.
- `ball_vy_in` in 8: signed Y velocity.
- `gravity_counter_in` in 2: gravity phase.
- `ball_fast_in` in 1: 1 selects the 270000 speed code at the receiver.
- `is_lose_in` in 1: local player lost, so the opponent gets the win flag.
- `m_start` out 1: one-cycle pulse that opens an I2C write transaction.
- `m_addr` out 7: equals `SLAVE_ADDR`.
- `m_data` out 8: current frame byte.
- `m_valid` out 1: `m_data` is valid.
- `m_last` out 1: the current byte is the final byte of the frame.
- `m_ready` in 1: byte accepted by the master (ACKed).
- `m_nack` in 1: slave NACK or arbitration loss.
- `m_stop_done` in 1: STOP condition completed.
- `ball_send_to_slave` out 1: busy; high from the cycle after capture until DONE exits.
- `is_i2c_master_done` out 1: completion level, held `DONE_HOLD` cycles.
- `frame_err` out 1: high during DONE if all retries failed.

## Operation
Frame bytes, in order:
- B0 = {`y[9:8]`, 6'b0}
- B1 = `y[7:0]`
- B2 = `vy`
- B3 = {6'b0, `grav`}
- B4 = {7'b0, `fast`}
- B5 = {7'b0, `lose`}

All fields come from a shadow register loaded at capture. Later changes on the inputs do not affect an in-flight frame.

State machine:
- **IDLE**
  - A rising edge of `ball_send_trigger` (the registered previous value is 0 and the current value is 1) loads the shadow register, sets the byte index to 0, clears the retry count, pulses `m_start`, and moves to SEND.
- **SEND**
  - `m_valid`=1 and `m_data`=B[idx].
  - `m_last`=1 when idx is the final byte.
  - On `m_ready`: if idx is final, go to WAIT_STOP; otherwise idx+1.
  - On `m_nack` or timeout: go to FAIL.
- **WAIT_STOP**
  - `m_valid`=0.
  - On `m_stop_done`: go to DONE with `frame_err`=0.
  - On timeout: go to FAIL.
- **FAIL**
  - One cycle long.
  - If retry count < `MAX_RETRY`: increment it, set idx to 0, pulse `m_start`, and go to SEND.
  - Otherwise: go to DONE with `frame_err`=1.
- **DONE**
  - `is_i2c_master_done`=1 for exactly `DONE_HOLD` cycles, then go to IDLE.
  - `ball_send_to_slave` drops on the same edge that enters IDLE.

Rules:
- The timeout counter clears on state entry and on every `m_ready`. It fires when it reaches `ACK_TIMEOUT`-1.
- `m_nack` and `m_ready` in the same cycle: NACK wins.
- `m_stop_done` is ignored in SEND.
- A trigger held high or re-asserted while not in IDLE is ignored. A new frame requires a fresh rising edge observed in IDLE. A trigger still high on return to IDLE does not restart the block.

## Timing
- Reset values:
  - All outputs are 0.
  - The state is IDLE, the shadow register, idx, retry and timeout counters are 0, and the previous-trigger flag is 0.
  - `m_addr` is constant.
  - Reset mid-frame forces these values immediately (asynchronous), including `m_valid`=0.
- Trigger rising edge sampled at edge N: `m_start` is high during cycle N+1, and so are `ball_send_to_slave` and `m_valid` with B0.
- Each byte holds until the cycle in which `m_ready`=1; the next byte is presented in the following cycle.
- `is_i2c_master_done` rises on the cycle after `m_stop_done` and after final FAIL.

## Configuration
- Macro `BALL_FRAME_CHECKSUM_EN`.
- Defined: a seventh byte B6 = XOR of B0–B5 is appended, and `m_last` moves to B6.
- Undefined: the frame is 6 bytes and `m_last` is on B5.

## Test plan
- **Nominal frame:** y=0x2A5, vy=-3 (0xFD), grav=2, fast=1, lose=0, trigger pulse, master ACKs every byte immediately.
  - Bytes are 0x80, 0xA5, 0xFD, 0x02, 0x01, 0x00.
  - `m_last` is on byte 6 (byte 7 = 0xDB with the macro).
  - Done is high for 4 cycles after `m_stop_done`.
- **Held trigger:** trigger held high for 1000 cycles.
  - Exactly one frame is sent.
  - There is no second `m_start` after DONE until trigger goes low then high.
- **NACK retry:** NACK on B2 of the first attempt.
  - `m_start` re-pulses and B0 is resent.
  - The second attempt completes with `frame_err`=0.
- **Retries exhausted:** NACK on every attempt with `MAX_RETRY`=2.
  - Exactly 3 `m_start` pulses.
  - DONE with `frame_err`=1 and done held for 4 cycles.
- **Timeout and reset:**
  - With `ACK_TIMEOUT`=16 and `m_ready` stuck at 0: FAIL is entered 16 cycles after SEND entry.
  - Asserting `reset_n`=0 mid-SEND drops `m_valid` and busy asynchronously.
- **Simultaneous and shadowed inputs:**
  - `m_ready` and `m_nack` asserted in the same cycle are treated as a NACK.
  - Changing `ball_y_in` during a frame leaves B0/B1 unchanged.
